cut_response_misr: RTL and testbench

- Downstream response-capture stage for the generated combinational circuit-under-test (5 inputs x0..x4, 19 outputs f1..f19).
- Accepts one 19-bit response vector per accepted transfer and compresses it into a multiple-input signature register (MISR).
- After NUM_VECTORS accepted vectors, compares the final signature against a golden value and reports pass or fail.
- Used by the dataset self-check harness to validate each generated netlist without storing full truth tables.

---
 rtl/cut_response_misr.sv | 118 +++++++++++
 tb/tb_cut_response_misr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cut_response_misr.sv
// Response-capture stage: folds CUT response vectors into a MISR and, after a
// fixed number of accepted vectors, compares the signature against a golden value.
module cut_response_misr #(
  parameter int              RESP_W      = 19,
  parameter int              SIG_W       = 24,
  parameter logic [SIG_W-1:0] POLY       = 24'h00001B,
  parameter logic [SIG_W-1:0] SEED       = 24'h000000,
  parameter int              NUM_VECTORS = 32,
  parameter int              CNT_W       = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_resp_valid,
  output logic              o_resp_ready,
  input  logic [RESP_W-1:0] i_resp_data,
  input  logic [SIG_W-1:0]  i_golden_sig,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail,
  output logic [SIG_W-1:0]  o_signature,
  output logic [CNT_W-1:0]  o_vec_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic             r_fail;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  logic [SIG_W-1:0] w_sig_next;
  logic             w_last;
  logic             w_match;

  // Shift with polynomial feedback, then fold the zero-extended response in.
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ SIG_W'(i_resp_data);
  assign w_last     = (r_cnt == CNT_W'(NUM_VECTORS - 1));
  assign w_match    = (w_sig_next == i_golden_sig);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else if (i_abort) begin
      // Abort wins over start and over a transfer; the signature is left as-is.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_resp_valid) begin
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_pass  <= w_match;
              r_fail  <= !w_match;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_resp_ready = r_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail       = r_fail;
  assign o_signature  = r_sig;
  assign o_vec_count  = r_cnt;

endmodule

// File: tb/tb_cut_response_misr.sv
// Bench for cut_response_misr: three instances (24, 25, 32 vectors) share stimulus;
// a behavioural model plus a completion scoreboard supply every expected value.
module tb_cut_response_misr;

  localparam logic [23:0] POLY = 24'h00001B;
  localparam logic [23:0] SEED = 24'h000000;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        abort;
  logic        valid;
  logic [18:0] data;
  logic [2:0]  ready, busy, done, pass, fail;
  logic [23:0] sig    [3];
  logic [5:0]  cnt    [3];
  logic [23:0] golden [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [23:0] sig;
    logic        pass;
    int          cnt;
  } exp_t;
  exp_t sbQ[$];

  logic [23:0] mSig  [3];
  int          mCnt  [3];
  bit          mRun  [3];
  bit          mDone [3];
  bit          mPass [3];
  bit          mFail [3];
  bit [2:0]    prevDone;
  logic [23:0] firstSig [3];

  function automatic int nvOf(input int k);
    return (k == 0) ? 24 : (k == 1) ? 25 : 32;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    cut_response_misr #(
      .NUM_VECTORS((k == 0) ? 24 : (k == 1) ? 25 : 32)
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_start      (start),
      .i_abort      (abort),
      .i_resp_valid (valid),
      .o_resp_ready (ready[k]),
      .i_resp_data  (data),
      .i_golden_sig (golden[k]),
      .o_busy       (busy[k]),
      .o_done       (done[k]),
      .o_pass       (pass[k]),
      .o_fail       (fail[k]),
      .o_signature  (sig[k]),
      .o_vec_count  (cnt[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [23:0] misrNext(input logic [23:0] s, input logic [18:0] d);
    logic [23:0] t;
    t = s << 1;
    if (s[23]) t = t ^ POLY;
    return t ^ {5'b0, d};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mSig[k] = SEED; mCnt[k] = 0; mRun[k] = 0;
      mDone[k] = 0; mPass[k] = 0; mFail[k] = 0;
    end
  endtask

  task automatic modelStep(input logic st, input logic ab, input logic v, input logic [18:0] d);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ab) begin
        mRun[k] = 0; mDone[k] = 0; mPass[k] = 0; mFail[k] = 0; mCnt[k] = 0;
      end else if (!mRun[k] && st) begin
        mRun[k] = 1; mDone[k] = 0; mPass[k] = 0; mFail[k] = 0; mCnt[k] = 0;
        mSig[k] = SEED;
      end else if (mRun[k] && v) begin
        mSig[k] = misrNext(mSig[k], d);
        mCnt[k]++;
        if (mCnt[k] == nvOf(k)) begin
          mRun[k]  = 0;
          mDone[k] = 1;
          mPass[k] = (mSig[k] == golden[k]);
          mFail[k] = !mPass[k];
          e.dut = k; e.sig = mSig[k]; e.pass = mPass[k]; e.cnt = mCnt[k];
          sbQ.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic v, input logic [18:0] d);
    start = st; abort = ab; valid = v; data = d;
    @(posedge clk);
    if (rstN) modelStep(st, ab, v, d);
    #1;
  endtask

  // Per-cycle comparison against the model, and scoreboard pop when done rises.
  always @(negedge clk) begin
    exp_t e;
    if (rstN) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("ready%0d", k), 32'(ready[k]), 32'(mRun[k]));
        checkOutput($sformatf("busy%0d", k),  32'(busy[k]),  32'(mRun[k]));
        checkOutput($sformatf("done%0d", k),  32'(done[k]),  32'(mDone[k]));
        checkOutput($sformatf("pass%0d", k),  32'(pass[k]),  32'(mPass[k]));
        checkOutput($sformatf("fail%0d", k),  32'(fail[k]),  32'(mFail[k]));
        checkOutput($sformatf("sig%0d", k),   32'(sig[k]),   32'(mSig[k]));
        checkOutput($sformatf("cnt%0d", k),   32'(cnt[k]),   32'(mCnt[k]));
        if (done[k] && !prevDone[k]) begin
          checkOutput($sformatf("sbPending%0d", k), 32'(sbQ.size() > 0), 32'd1);
          if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("sbDut", 32'(k), 32'(e.dut));
            checkOutput($sformatf("sbSig%0d", k),  32'(sig[k]),  32'(e.sig));
            checkOutput($sformatf("sbPass%0d", k), 32'(pass[k]), 32'(e.pass));
            checkOutput($sformatf("sbCnt%0d", k),  32'(cnt[k]),  32'(e.cnt));
          end
        end
      end
    end
    prevDone = done;
  end

  task automatic runSingleBit();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, (i == 0) ? 19'h00001 : 19'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    golden[0] = 24'h800000; golden[1] = 24'h00001B; golden[2] = 24'h000001;
    prevDone = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    $display("[TB] single-bit propagation and feedback tap");
    runSingleBit();
    checkOutput("sb24Sig",  32'(sig[0]),  32'h800000);
    checkOutput("sb24Pass", 32'(pass[0]), 32'd1);
    checkOutput("sb24Cnt",  32'(cnt[0]),  32'd24);
    checkOutput("fb25Sig",  32'(sig[1]),  32'h00001B);
    checkOutput("fb25Pass", 32'(pass[1]), 32'd1);
    checkOutput("run32Done", 32'(done[2]), 32'd1);
    for (int k = 0; k < 3; k++) firstSig[k] = mSig[k];

    $display("[TB] restart from done");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("restartSig",  32'(sig[2]),  32'(SEED));
    checkOutput("restartPass", 32'(pass[0]), 32'd0);
    checkOutput("restartBusy", 32'(busy[2]), 32'd1);
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, (i == 0) ? 19'h00001 : 19'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("repeatSig%0d", k), 32'(sig[k]), 32'(firstSig[k]));

    $display("[TB] mismatch with back-pressure");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 63; i++)
      applyStimulus(1'b0, 1'b0, (i % 2) == 0, '0);
    checkOutput("bpDone", 32'(done[2]), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("bpFail", 32'(fail[2]), 32'd1);
    checkOutput("bpPass", 32'(pass[2]), 32'd0);
    checkOutput("bpSig",  32'(sig[2]),  32'h0);
    checkOutput("bpCnt",  32'(cnt[2]),  32'd32);

    $display("[TB] abort priority");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 19'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, 19'h7FFFF);
    checkOutput("abortReady", 32'(ready[2]), 32'd0);
    checkOutput("abortCnt",   32'(cnt[2]),   32'd0);
    checkOutput("abortPass",  32'(pass[2]),  32'd0);
    checkOutput("abortFail",  32'(fail[2]),  32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 19'h00123);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 19'($urandom) | 19'h1);
    rstN = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rstBusy%0d", k),  32'(busy[k]),  32'd0);
      checkOutput($sformatf("rstReady%0d", k), 32'(ready[k]), 32'd0);
      checkOutput($sformatf("rstDone%0d", k),  32'(done[k]),  32'd0);
      checkOutput($sformatf("rstPass%0d", k),  32'(pass[k]),  32'd0);
      checkOutput($sformatf("rstFail%0d", k),  32'(fail[k]),  32'd0);
      checkOutput($sformatf("rstSig%0d", k),   32'(sig[k]),   32'h0);
      checkOutput($sformatf("rstCnt%0d", k),   32'(cnt[k]),   32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 19'h00001);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
